cdb_arbiter: RTL and testbench

Shares the two common data bus ports (cdb and cdb2) between NUM_FU functional-unit result sources (ALU, multiplier, load/store, branch units).
- Each FU gets a one-entry result holding slot.
- A rotating-priority arbiter drains up to two slots per cycle onto the buses.
- The buses feed the reservation-station wakeup logic, the register file and the ROB.

---
 rtl/cdb_arbiter.sv | 126 ++++++++++++
 tb/tb_cdb_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Per-FU one-entry result slots drained onto two common data buses by a rotating-priority scan.
// Latency: a slot loaded at edge t drives a bus in cycle t+1 at the earliest; a full slot deasserts fu_ready until granted.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int PD_W   = 6,
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU-1:0][PD_W-1:0]    fu_pd,
  input  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  output logic                           cdb_valid,
  output logic [PD_W-1:0]                cdb_pd,
  output logic [ROB_W-1:0]               cdb_rob,
  output logic [DATA_W-1:0]              cdb_data,
  output logic                           cdb2_valid,
  output logic [PD_W-1:0]                cdb2_pd,
  output logic [ROB_W-1:0]               cdb2_rob,
  output logic [DATA_W-1:0]              cdb2_data
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [PD_W-1:0]   pd;
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] data;
  } res_t;

  res_t [NUM_FU-1:0] slot_q, slot_d;
  logic [NUM_FU-1:0] slot_vld_q, slot_vld_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic              g0_vld, g1_vld;
  logic [PTR_W-1:0]  g0, g1;
  logic [NUM_FU-1:0] granted;
  logic [NUM_FU-1:0] load;

  // Increment modulo NUM_FU, which need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (int'(p) == NUM_FU - 1) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    int idx;
    idx    = 0;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0     = '0;
    g1     = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = (int'(ptr_q) + k) % NUM_FU;
      if (slot_vld_q[idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0     = PTR_W'(idx);
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1     = PTR_W'(idx);
        end
      end
    end
  end

  always_comb begin
    granted = '0;
    if (g0_vld) granted[g0] = 1'b1;
    if (g1_vld) granted[g1] = 1'b1;
  end

  // A slot being drained this cycle may reload on the same edge.
  assign fu_ready = {NUM_FU{rst & ~flush}} & (~slot_vld_q | granted);
  assign load     = fu_valid & fu_ready;

  assign cdb_valid  = g0_vld & ~flush;
  assign cdb_pd     = cdb_valid ? slot_q[g0].pd   : '0;
  assign cdb_rob    = cdb_valid ? slot_q[g0].rob  : '0;
  assign cdb_data   = cdb_valid ? slot_q[g0].data : '0;

  assign cdb2_valid = g1_vld & ~flush;
  assign cdb2_pd    = cdb2_valid ? slot_q[g1].pd   : '0;
  assign cdb2_rob   = cdb2_valid ? slot_q[g1].rob  : '0;
  assign cdb2_data  = cdb2_valid ? slot_q[g1].data : '0;

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_d     = slot_q;
    ptr_d      = ptr_q;
    if (flush) begin
      slot_vld_d = '0;
      ptr_d      = '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (load[i]) begin
          slot_vld_d[i]  = 1'b1;
          slot_d[i].pd   = fu_pd[i];
          slot_d[i].rob  = fu_rob[i];
          slot_d[i].data = fu_data[i];
        end else if (granted[i]) begin
          slot_vld_d[i] = 1'b0;
        end
      end
      if (g1_vld)      ptr_d = wrap_inc(g1);
      else if (g0_vld) ptr_d = wrap_inc(g0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld_q <= '0;
      slot_q     <= '0;
      ptr_q      <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_q     <= slot_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter against a slot/queue reference model.
module tb_cdb_arbiter;

  localparam int N     = 4;
  localparam int PD_W  = 6;
  localparam int ROB_W = 5;
  localparam int DW    = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     flush = 1'b0;
  logic [N-1:0]             fu_valid = '0;
  logic [N-1:0][PD_W-1:0]   fu_pd = '0;
  logic [N-1:0][ROB_W-1:0]  fu_rob = '0;
  logic [N-1:0][DW-1:0]     fu_data = '0;
  logic [N-1:0]             fu_ready;
  logic                     cdb_valid, cdb2_valid;
  logic [PD_W-1:0]          cdb_pd, cdb2_pd;
  logic [ROB_W-1:0]         cdb_rob, cdb2_rob;
  logic [DW-1:0]            cdb_data, cdb2_data;

  int checks = 0;
  int failures = 0;

  bit               m_vld[N];
  logic [PD_W-1:0]  m_pd[N];
  logic [ROB_W-1:0] m_rob[N];
  logic [DW-1:0]    m_data[N];
  int               m_ptr = 0;

  cdb_arbiter #(.NUM_FU(N), .PD_W(PD_W), .ROB_W(ROB_W), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_pd(fu_pd), .fu_rob(fu_rob), .fu_data(fu_data),
    .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
    .cdb2_valid(cdb2_valid), .cdb2_pd(cdb2_pd), .cdb2_rob(cdb2_rob), .cdb2_data(cdb2_data)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    m_ptr = 0;
  endtask

  // Collect occupied slots in rotation order starting at the pointer; first two win.
  task automatic model_grants(output int g0, output int g1);
    int order[$];
    order = {};
    for (int k = 0; k < N; k++) begin
      if (m_vld[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
    end
    g0 = (order.size() > 0) ? order[0] : -1;
    g1 = (order.size() > 1) ? order[1] : -1;
  endtask

  task automatic model_edge();
    int g0, g1;
    bit gr;
    if (!rst) begin
      model_reset();
      return;
    end
    model_grants(g0, g1);
    if (flush) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      gr = (i == g0) || (i == g1);
      if (fu_valid[i] && (!m_vld[i] || gr)) begin
        m_vld[i]  = 1'b1;
        m_pd[i]   = fu_pd[i];
        m_rob[i]  = fu_rob[i];
        m_data[i] = fu_data[i];
      end else if (gr) begin
        m_vld[i] = 1'b0;
      end
    end
    if (g1 >= 0)      m_ptr = (g1 + 1) % N;
    else if (g0 >= 0) m_ptr = (g0 + 1) % N;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fu_valid = '1;
    #3;
    checks++; if (cdb_valid !== 1'b0 || cdb2_valid !== 1'b0) begin failures++;
      $display("FAIL reset_bus_valid got %b/%b want 0/0", cdb_valid, cdb2_valid); end
    checks++; if (fu_ready !== 4'b0000) begin failures++;
      $display("FAIL reset_ready got %b want 0000", fu_ready); end
    checks++; if ({cdb_pd, cdb_rob, cdb_data, cdb2_pd, cdb2_rob, cdb2_data} !== '0) begin failures++;
      $display("FAIL reset_payload got %h/%h want 0", cdb_data, cdb2_data); end
    tick();
    tick();
    fu_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (fu_ready !== 4'b1111 || cdb_valid !== 1'b0) begin failures++;
      $display("FAIL post_reset got ready=%b cdb_valid=%b want 1111/0", fu_ready, cdb_valid); end
    tick();
  endtask

  task automatic test_single();
    fu_valid = 4'b0100;
    fu_pd[2] = 6'd5; fu_rob[2] = 5'd3; fu_data[2] = 32'hDEAD;
    tick();
    fu_valid = '0;
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b1 || cdb_pd !== 6'd5 || cdb_rob !== 5'd3 || cdb_data !== 32'hDEAD) begin
      failures++; $display("FAIL single_cdb got v=%b pd=%0d rob=%0d data=%h want 1/5/3/dead",
                           cdb_valid, cdb_pd, cdb_rob, cdb_data); end
    checks++; if (cdb2_valid !== 1'b0) begin failures++;
      $display("FAIL single_cdb2 got %b want 0", cdb2_valid); end
    tick();
    checks++; if (dut.ptr_q !== 2'd3) begin failures++;
      $display("FAIL single_ptr got %0d want 3", dut.ptr_q); end
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0) begin failures++;
      $display("FAIL single_drained got %b want 0", cdb_valid); end
    tick();
  endtask

  task automatic test_all_four();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fu_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      fu_pd[i] = PD_W'(10 + i); fu_rob[i] = ROB_W'(4 + i); fu_data[i] = 32'h100 + i;
    end
    tick();
    fu_valid = '0;
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b1 || cdb_pd !== 6'd10 || cdb_data !== 32'h100) begin failures++;
      $display("FAIL all4_first_cdb got pd=%0d data=%h want 10/100", cdb_pd, cdb_data); end
    checks++; if (cdb2_valid !== 1'b1 || cdb2_pd !== 6'd11 || cdb2_rob !== 5'd5) begin failures++;
      $display("FAIL all4_first_cdb2 got pd=%0d rob=%0d want 11/5", cdb2_pd, cdb2_rob); end
    checks++; if (fu_ready !== 4'b0011) begin failures++;
      $display("FAIL all4_ready got %b want 0011", fu_ready); end
    tick();
    @(negedge clk);
    checks++; if (cdb_pd !== 6'd12 || cdb2_pd !== 6'd13 || cdb2_data !== 32'h103) begin failures++;
      $display("FAIL all4_second got pd=%0d/%0d want 12/13", cdb_pd, cdb2_pd); end
    tick();
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0 || cdb2_valid !== 1'b0) begin failures++;
      $display("FAIL all4_empty got %b/%b want 0/0", cdb_valid, cdb2_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    fu_valid = 4'b0010;
    fu_data[1] = 32'd1;
    tick();
    for (int k = 2; k <= 4; k++) begin
      fu_data[1] = DW'(k);
      @(negedge clk);
      checks++; if (cdb_valid !== 1'b1 || cdb_data !== DW'(k - 1) || fu_ready[1] !== 1'b1) begin
        failures++; $display("FAIL b2b_%0d got v=%b data=%0d rdy=%b want 1/%0d/1",
                             k - 1, cdb_valid, cdb_data, fu_ready[1], k - 1); end
      tick();
    end
    fu_valid = '0;
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b1 || cdb_data !== 32'd4) begin failures++;
      $display("FAIL b2b_4 got v=%b data=%0d want 1/4", cdb_valid, cdb_data); end
    tick();
  endtask

  task automatic test_wrap();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fu_valid = 4'b0100;
    fu_pd[2] = 6'd22;
    tick();
    fu_valid = 4'b1001;
    fu_pd[3] = 6'd33; fu_data[3] = 32'h3333;
    fu_pd[0] = 6'd30; fu_data[0] = 32'h3030;
    tick();
    fu_valid = '0;
    checks++; if (dut.ptr_q !== 2'd3) begin failures++;
      $display("FAIL wrap_ptr_pre got %0d want 3", dut.ptr_q); end
    @(negedge clk);
    checks++; if (cdb_pd !== 6'd33 || cdb_data !== 32'h3333 || cdb2_pd !== 6'd30 || cdb2_data !== 32'h3030) begin
      failures++; $display("FAIL wrap_buses got pd=%0d/%0d want 33/30", cdb_pd, cdb2_pd); end
    tick();
    checks++; if (dut.ptr_q !== 2'd1) begin failures++;
      $display("FAIL wrap_ptr_post got %0d want 1", dut.ptr_q); end
  endtask

  task automatic test_flush();
    fu_valid = 4'b1110;
    tick();
    flush = 1'b1;
    fu_valid = 4'b0001;
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0 || cdb2_valid !== 1'b0 || cdb_data !== '0) begin failures++;
      $display("FAIL flush_buses got %b/%b want 0/0", cdb_valid, cdb2_valid); end
    checks++; if (fu_ready !== 4'b0000) begin failures++;
      $display("FAIL flush_ready got %b want 0000", fu_ready); end
    tick();
    flush = 1'b0;
    fu_valid = '0;
    checks++; if (dut.ptr_q !== 2'd0 || dut.slot_vld_q !== 4'b0000) begin failures++;
      $display("FAIL flush_state got ptr=%0d vld=%b want 0/0000", dut.ptr_q, dut.slot_vld_q); end
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0 || cdb2_valid !== 1'b0) begin failures++;
      $display("FAIL flush_after got %b/%b want 0/0", cdb_valid, cdb2_valid); end
    tick();
  endtask

  task automatic test_async_reset();
    fu_valid = 4'b0011;
    tick();
    fu_valid = '0;
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b1 || cdb2_valid !== 1'b1) begin failures++;
      $display("FAIL areset_pre got %b/%b want 1/1", cdb_valid, cdb2_valid); end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (cdb_valid !== 1'b0 || cdb2_valid !== 1'b0 || fu_ready !== 4'b0000) begin failures++;
      $display("FAIL areset_immediate got %b/%b rdy=%b want 0/0/0000", cdb_valid, cdb2_valid, fu_ready); end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cdb_valid !== 1'b0 || cdb2_valid !== 1'b0) begin failures++;
      $display("FAIL areset_stale got %b/%b want 0/0", cdb_valid, cdb2_valid); end
    tick();
  endtask

  task automatic test_random();
    int g0, g1;
    logic [N-1:0] exp_rdy;
    logic e_v0, e_v1;
    logic [PD_W+ROB_W+DW-1:0] e_p0, e_p1;
    for (int it = 0; it < 400; it++) begin
      fu_valid = N'($urandom);
      flush = ($urandom_range(15) == 0);
      for (int i = 0; i < N; i++) begin
        fu_pd[i] = PD_W'($urandom); fu_rob[i] = ROB_W'($urandom); fu_data[i] = $urandom;
      end
      @(negedge clk);
      model_grants(g0, g1);
      for (int i = 0; i < N; i++)
        exp_rdy[i] = !flush && (!m_vld[i] || i == g0 || i == g1);
      e_v0 = (g0 >= 0) && !flush;
      e_v1 = (g1 >= 0) && !flush;
      e_p0 = e_v0 ? {m_pd[g0], m_rob[g0], m_data[g0]} : '0;
      e_p1 = e_v1 ? {m_pd[g1], m_rob[g1], m_data[g1]} : '0;
      checks++; if (fu_ready !== exp_rdy) begin failures++;
        $display("FAIL rnd_ready it=%0d got %b want %b", it, fu_ready, exp_rdy); end
      checks++; if (cdb_valid !== e_v0 || {cdb_pd, cdb_rob, cdb_data} !== e_p0) begin failures++;
        $display("FAIL rnd_cdb it=%0d got %b/%h want %b/%h", it, cdb_valid, {cdb_pd, cdb_rob, cdb_data}, e_v0, e_p0); end
      checks++; if (cdb2_valid !== e_v1 || {cdb2_pd, cdb2_rob, cdb2_data} !== e_p1) begin failures++;
        $display("FAIL rnd_cdb2 it=%0d got %b/%h want %b/%h", it, cdb2_valid, {cdb2_pd, cdb2_rob, cdb2_data}, e_v1, e_p1); end
      checks++; if (int'(dut.ptr_q) !== m_ptr) begin failures++;
        $display("FAIL rnd_ptr it=%0d got %0d want %0d", it, dut.ptr_q, m_ptr); end
      tick();
    end
    flush = 1'b0;
    fu_valid = '0;
    tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
